// File: rtl/mdu_defs.sv
// mdu_defs: MDU opcodes, default latencies and opcode helpers shared by the MDU files
package mdu_defs;
  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  function automatic logic is_start(input logic [3:0] op);
    return op == MDU_MULT || op == MDU_MULTU || op == MDU_DIV || op == MDU_DIVU;
  endfunction
  function automatic logic is_div(input logic [3:0] op);
    return op == MDU_DIV || op == MDU_DIVU;
  endfunction
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit mult / 32-bit div result for the MDU opcode
module mdu_arith
  import mdu_defs::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        wr_o
);
  logic        sgn, neg_a, neg_b, div;
  logic [31:0] ma, mb, den, q, r, qs, rs;
  logic [63:0] prod, prod_s;
  // Signed ops run on magnitudes and re-apply signs, so 0x80000000/-1 wraps to 0x80000000 cleanly
  always_comb begin
    sgn    = op_i == MDU_MULT || op_i == MDU_DIV;
    div    = is_div(op_i);
    neg_a  = sgn && a_i[31];
    neg_b  = sgn && b_i[31];
    ma     = neg_a ? -a_i : a_i;
    mb     = neg_b ? -b_i : b_i;
    prod   = {32'b0, ma} * {32'b0, mb};
    prod_s = (neg_a ^ neg_b) ? -prod : prod;
    den    = mb == 32'd0 ? 32'd1 : mb;
    q      = ma / den;
    r      = ma % den;
    qs     = (neg_a ^ neg_b) ? -q : q;
    rs     = neg_a ? -r : r;
    hi_o   = div ? rs : prod_s[63:32];
    lo_o   = div ? qs : prod_s[31:0];
    wr_o   = !(div && b_i == 32'd0);
  end
endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: EX-stage multiply/divide unit owning HI/LO with a busy counter modelling latency
module ex_mdu
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDU_op,
  input  logic [31:0] E_V1,
  input  logic [31:0] E_V2,
  input  logic        req,
  output logic        E_start,
  output logic        E_busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO,
  output logic [31:0] E_MDU_out
);
  localparam int CMAX = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] MC = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DC = CW'(DIV_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d, a_hi, a_lo;
  logic          pwr_q, pwr_d, a_wr, issue, commit, mt_ok;
  mdu_arith u_arith (
    .op_i(E_MDU_op),
    .a_i (E_V1),
    .b_i (E_V2),
    .hi_o(a_hi),
    .lo_o(a_lo),
    .wr_o(a_wr)
  );
  assign E_start   = is_start(E_MDU_op);
  assign E_busy    = cnt_q != '0;
  assign E_HI      = hi_q;
  assign E_LO      = lo_q;
  assign E_MDU_out = E_MDU_op == MDU_MFHI ? hi_q : E_MDU_op == MDU_MFLO ? lo_q : 32'd0;
  // Pending write-enable drops for divide-by-zero so commit leaves HI/LO untouched
  always_comb begin
    issue  = E_start && !E_busy && !req;
    mt_ok  = !req && !E_busy;
    commit = cnt_q == CW'(1) && pwr_q;
    cnt_d  = issue ? (is_div(E_MDU_op) ? DC : MC) : (E_busy ? cnt_q - 1'b1 : cnt_q);
    phi_d  = issue ? a_hi : phi_q;
    plo_d  = issue ? a_lo : plo_q;
    pwr_d  = issue ? a_wr : pwr_q;
    hi_d   = commit ? phi_q : (mt_ok && E_MDU_op == MDU_MTHI) ? E_V1 : hi_q;
    lo_d   = commit ? plo_q : (mt_ok && E_MDU_op == MDU_MTLO) ? E_V1 : lo_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      phi_q <= '0;
      plo_q <= '0;
      pwr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      pwr_q <= pwr_d;
    end
  end
endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed self-checking bench for ex_mdu with hand-computed HI/LO values
module tb_ex_mdu;
  import mdu_defs::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  E_MDU_op = MDU_NONE;
  logic [31:0] E_V1 = '0;
  logic [31:0] E_V2 = '0;
  logic        req = 1'b0;
  logic        E_start, E_busy;
  logic [31:0] E_HI, E_LO, E_MDU_out;
  int checks = 0;
  int failures = 0;
  ex_mdu dut (
    .clk(clk),
    .reset(reset),
    .E_MDU_op(E_MDU_op),
    .E_V1(E_V1),
    .E_V2(E_V2),
    .req(req),
    .E_start(E_start),
    .E_busy(E_busy),
    .E_HI(E_HI),
    .E_LO(E_LO),
    .E_MDU_out(E_MDU_out)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Issue op at the next edge, hold bop/breq during the n busy cycles, then check commit
  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int n, input logic [3:0] bop, input logic breq,
                     input logic [31:0] eh, input logic [31:0] el);
    E_MDU_op = op;
    E_V1 = a;
    E_V2 = b;
    tick();
    E_MDU_op = bop;
    req = breq;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, {31'b0, E_busy}, 32'd1);
      tick();
    end
    E_MDU_op = MDU_NONE;
    req = 1'b0;
    chk({tag, "_idle"}, {31'b0, E_busy}, 32'd0);
    chk({tag, "_hi"}, E_HI, eh);
    chk({tag, "_lo"}, E_LO, el);
  endtask
  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", {31'b0, E_busy}, 32'd0);
    chk("rst_hi", E_HI, 32'd0);
    chk("rst_lo", E_LO, 32'd0);
    chk("rst_out", E_MDU_out, 32'd0);
    chk("rst_start", {31'b0, E_start}, 32'd0);
    E_MDU_op = MDU_DIVU;
    #1;
    chk("start_comb", {31'b0, E_start}, 32'd1);
    run("mult", MDU_MULT, 32'hFFFF_FFFF, 32'd2, 5, MDU_NONE, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 5, MDU_NONE, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
    run("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10, MDU_NONE, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu", MDU_DIVU, 32'd7, 32'd2, 10, MDU_NONE, 1'b0, 32'd1, 32'd3);
    run("div0", MDU_DIV, 32'd5, 32'd0, 10, MDU_NONE, 1'b0, 32'd1, 32'd3);
    run("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, MDU_NONE, 1'b0, 32'd0, 32'h8000_0000);
    E_MDU_op = MDU_MTHI;
    E_V1 = 32'h1234;
    tick();
    E_MDU_op = MDU_MFHI;
    #1;
    chk("mthi_mfhi", E_MDU_out, 32'h1234);
    E_MDU_op = MDU_MTLO;
    E_V1 = 32'hDEAD;
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("mtlo_req", E_LO, 32'h8000_0000);
    E_MDU_op = MDU_MTLO;
    E_V1 = 32'h55;
    tick();
    E_MDU_op = MDU_MFLO;
    #1;
    chk("mtlo_mflo", E_MDU_out, 32'h55);
    E_MDU_op = MDU_MULT;
    E_V1 = 32'd3;
    E_V2 = 32'd3;
    req = 1'b1;
    tick();
    req = 1'b0;
    E_MDU_op = MDU_NONE;
    chk("mult_req_busy", {31'b0, E_busy}, 32'd0);
    chk("mult_req_lo", E_LO, 32'h55);
    run("mult_req_inflight", MDU_MULT, 32'd6, 32'd7, 5, MDU_NONE, 1'b1, 32'd0, 32'd42);
    E_V2 = 32'd3;
    run("restart_ign", MDU_MULT, 32'd3, 32'd3, 5, MDU_DIV, 1'b0, 32'd0, 32'd9);
    E_V1 = 32'd9;
    E_V2 = 32'd3;
    tick();
    chk("restart_noissue", {31'b0, E_busy}, 32'd0);
    E_MDU_op = MDU_DIVU;
    E_V1 = 32'd100;
    E_V2 = 32'd7;
    tick();
    E_MDU_op = MDU_NONE;
    tick();
    tick();
    tick();
    chk("mid_div_busy", {31'b0, E_busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_div_busy", {31'b0, E_busy}, 32'd0);
    chk("rst_div_hi", E_HI, 32'd0);
    chk("rst_div_lo", E_LO, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("rst_div_late_hi", E_HI, 32'd0);
    chk("rst_div_late_lo", E_LO, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
